// File: rtl/lorenz_stepper.sv
// rtl/lorenz_stepper.sv - forward-Euler Lorenz solver, one shared multiplier, handshaked runs
module lorenz_stepper #(
  parameter int WIDTH    = 27,
  parameter int FRAC     = 20,
  parameter int DT_SHIFT = 8,
  parameter int DECIM    = 1,
  parameter int CNT_W    = 32,
  parameter int SATURATE = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    stop,
  input  logic [CNT_W-1:0]        num_steps,
  input  logic signed [WIDTH-1:0] initial_x,
  input  logic signed [WIDTH-1:0] initial_y,
  input  logic signed [WIDTH-1:0] initial_z,
  input  logic signed [WIDTH-1:0] sigma,
  input  logic signed [WIDTH-1:0] rho,
  input  logic signed [WIDTH-1:0] beta,
  output logic signed [WIDTH-1:0] x_out,
  output logic signed [WIDTH-1:0] y_out,
  output logic signed [WIDTH-1:0] z_out,
  output logic                    sample_valid,
  output logic                    busy,
  output logic                    done,
  output logic [CNT_W-1:0]        step_count,
  output logic                    overflow
);
  localparam int PW = 2 * WIDTH;
  localparam int DW = $clog2(DECIM + 1);
  localparam logic signed [PW-1:0]    MAXV = {{(PW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [PW-1:0]    MINV = {{(PW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
  localparam logic signed [WIDTH-1:0] MAXW = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] MINW = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, M0, M1, M2, M3, UPD} state_t;
  state_t state, state_nx;

  logic signed [WIDTH-1:0] sig_r, rho_r, beta_r;
  logic [CNT_W-1:0]        nsteps_r;
  logic [DW-1:0]           dec_cnt;
  logic                    stop_pend;
  logic signed [PW-1:0]    p0, p1, p2, p3;

  function automatic logic signed [WIDTH:0] sx1(input logic signed [WIDTH-1:0] v);
    return {v[WIDTH-1], v};
  endfunction

  function automatic logic signed [PW-1:0] sx2(input logic signed [WIDTH-1:0] v);
    return {{(PW-WIDTH){v[WIDTH-1]}}, v};
  endfunction

  function automatic logic out_of_range(input logic signed [PW-1:0] v);
    return (v > MAXV) || (v < MINV);
  endfunction

  function automatic logic signed [WIDTH-1:0] fit(input logic signed [PW-1:0] v);
    if (SATURATE != 0 && v > MAXV) return MAXW;
    if (SATURATE != 0 && v < MINV) return MINW;
    return v[WIDTH-1:0];
  endfunction

  // Operands are one bit wider than the state so (y-x) and (rho-z) never wrap.
  logic signed [WIDTH:0]     mul_a, mul_b;
  logic signed [2*WIDTH+1:0] mul_full;
  logic signed [PW-1:0]      mul_p;

  always_comb begin
    mul_a = '0;
    mul_b = '0;
    case (state)
      M0: begin mul_a = sx1(sig_r);  mul_b = sx1(y_out) - sx1(x_out); end
      M1: begin mul_a = sx1(x_out);  mul_b = sx1(rho_r) - sx1(z_out); end
      M2: begin mul_a = sx1(x_out);  mul_b = sx1(y_out);              end
      M3: begin mul_a = sx1(beta_r); mul_b = sx1(z_out);              end
      default: ;
    endcase
    mul_full = mul_a * mul_b;
    mul_p    = PW'(mul_full >>> FRAC);
  end

  logic signed [PW-1:0] dy, dz, nx_w, ny_w, nz_w;
  logic [CNT_W-1:0]     cnt_inc;
  logic [DW-1:0]        dec_inc;
  logic                 finish, step_ovf;

  always_comb begin
    dy       = p1 - sx2(y_out);
    dz       = p2 - p3;
    nx_w     = sx2(x_out) + (p0 >>> DT_SHIFT);
    ny_w     = sx2(y_out) + (dy >>> DT_SHIFT);
    nz_w     = sx2(z_out) + (dz >>> DT_SHIFT);
    step_ovf = out_of_range(nx_w) || out_of_range(ny_w) || out_of_range(nz_w);
    cnt_inc  = step_count + CNT_W'(1);
    dec_inc  = dec_cnt + DW'(1);
    // A stop arriving in the UPD cycle itself still ends the run at this boundary.
    finish   = (cnt_inc == nsteps_r) || stop_pend || stop;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start && num_steps != '0) state_nx = M0;
      M0:      state_nx = M1;
      M1:      state_nx = M2;
      M2:      state_nx = M3;
      M3:      state_nx = UPD;
      UPD:     state_nx = finish ? IDLE : M0;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sig_r <= '0; rho_r <= '0; beta_r <= '0; nsteps_r <= '0;
      x_out <= '0; y_out <= '0; z_out <= '0;
      p0 <= '0; p1 <= '0; p2 <= '0; p3 <= '0;
      dec_cnt <= '0; stop_pend <= 1'b0; step_count <= '0;
      overflow <= 1'b0; busy <= 1'b0; done <= 1'b0; sample_valid <= 1'b0;
    end else begin
      done         <= 1'b0;
      sample_valid <= 1'b0;
      if (state != IDLE && stop) stop_pend <= 1'b1;
      case (state)
        IDLE: if (start) begin
          sig_r <= sigma; rho_r <= rho; beta_r <= beta; nsteps_r <= num_steps;
          x_out <= initial_x; y_out <= initial_y; z_out <= initial_z;
          step_count <= '0; overflow <= 1'b0; dec_cnt <= '0; stop_pend <= 1'b0;
          if (num_steps == '0) done <= 1'b1;
          else                 busy <= 1'b1;
        end
        M0: p0 <= mul_p;
        M1: p1 <= mul_p;
        M2: p2 <= mul_p;
        M3: p3 <= mul_p;
        UPD: begin
          x_out      <= fit(nx_w);
          y_out      <= fit(ny_w);
          z_out      <= fit(nz_w);
          step_count <= cnt_inc;
          stop_pend  <= 1'b0;
          if (step_ovf) overflow <= 1'b1;
          if (dec_inc == DW'(DECIM)) begin
            dec_cnt      <= '0;
            sample_valid <= 1'b1;
          end else begin
            dec_cnt <= dec_inc;
          end
          if (finish) begin
            done <= 1'b1;
            busy <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_lorenz_stepper.sv
// tb/tb_lorenz_stepper.sv - randomized bench for lorenz_stepper against a step-level reference model
module tb_lorenz_stepper;
  localparam longint HALF = 64'sd67108864;
  localparam longint FULL = 64'sd134217728;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic stop = 1'b0;
  logic [31:0] num_steps = '0;
  logic signed [26:0] initial_x = '0, initial_y = '0, initial_z = '0;
  logic signed [26:0] sigma = '0, rho = '0, beta = '0;

  logic signed [26:0] x0, y0, z0, x1, y1, z1, x2, y2, z2;
  logic sv0, bz0, dn0, ov0, sv1, bz1, dn1, ov1, sv2, bz2, dn2, ov2;
  logic [31:0] sc0, sc1, sc2;

  int total = 0;
  int bad = 0;
  int nrun = 0;
  longint xs[2][101], ys[2][101], zs[2][101];
  bit ovc[2][101];

  always #5 clk = ~clk;

  lorenz_stepper u_sat (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .num_steps(num_steps),
    .initial_x(initial_x), .initial_y(initial_y), .initial_z(initial_z),
    .sigma(sigma), .rho(rho), .beta(beta),
    .x_out(x0), .y_out(y0), .z_out(z0), .sample_valid(sv0), .busy(bz0),
    .done(dn0), .step_count(sc0), .overflow(ov0));

  lorenz_stepper #(.DECIM(4)) u_dec (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .num_steps(num_steps),
    .initial_x(initial_x), .initial_y(initial_y), .initial_z(initial_z),
    .sigma(sigma), .rho(rho), .beta(beta),
    .x_out(x1), .y_out(y1), .z_out(z1), .sample_valid(sv1), .busy(bz1),
    .done(dn1), .step_count(sc1), .overflow(ov1));

  lorenz_stepper #(.SATURATE(0)) u_wrap (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .num_steps(num_steps),
    .initial_x(initial_x), .initial_y(initial_y), .initial_z(initial_z),
    .sigma(sigma), .rho(rho), .beta(beta),
    .x_out(x2), .y_out(y2), .z_out(z2), .sample_valid(sv2), .busy(bz2),
    .done(dn2), .step_count(sc2), .overflow(ov2));

  task automatic chk(input string tag, input longint got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint fit(input longint v, input bit sat, output bit o);
    longint w;
    o = (v > HALF - 1) || (v < -HALF);
    if (!o) return v;
    if (sat) return (v > 0) ? HALF - 1 : -HALF;
    w = v & (FULL - 1);
    if (w >= HALF) w = w - FULL;
    return w;
  endfunction

  // Trajectory 0 saturates, trajectory 1 wraps; entry k is the state after k steps.
  task automatic model(input longint ix, iy, iz, sg, rh, bt, input int n);
    longint x, y, z, p0, p1, p2, p3;
    bit o1, o2, o3;
    for (int v = 0; v < 2; v++) begin
      xs[v][0] = ix; ys[v][0] = iy; zs[v][0] = iz; ovc[v][0] = 1'b0;
      for (int k = 1; k <= n; k++) begin
        x = xs[v][k-1]; y = ys[v][k-1]; z = zs[v][k-1];
        p0 = (sg * (y - x)) >>> 20;
        p1 = (x * (rh - z)) >>> 20;
        p2 = (x * y) >>> 20;
        p3 = (bt * z) >>> 20;
        xs[v][k] = fit(x + (p0 >>> 8), v == 0, o1);
        ys[v][k] = fit(y + ((p1 - y) >>> 8), v == 0, o2);
        zs[v][k] = fit(z + ((p2 - p3) >>> 8), v == 0, o3);
        ovc[v][k] = ovc[v][k-1] | o1 | o2 | o3;
      end
    end
  endtask

  task automatic chk_inst(input string tag, input int t, input int dec, input int tr,
                          input logic b, d, s, o, input longint x, y, z, sc);
    int k;
    logic [3:0] e;
    k = (t - 1) / 5;
    if (k > nrun) k = nrun;
    e[3] = (nrun > 0) && (t <= 5 * nrun);
    e[2] = (t == 5 * nrun + 1);
    e[1] = (nrun > 0) && (t > 1) && ((t - 1) % 5 == 0) && ((t - 1) / 5 <= nrun)
           && (((t - 1) / 5) % dec == 0);
    e[0] = ovc[tr][k];
    chk($sformatf("%s ctrl t=%0d", tag, t), longint'({b, d, s, o}), longint'(e));
    chk($sformatf("%s x t=%0d", tag, t), x, xs[tr][k]);
    chk($sformatf("%s y t=%0d", tag, t), y, ys[tr][k]);
    chk($sformatf("%s z t=%0d", tag, t), z, zs[tr][k]);
    chk($sformatf("%s steps t=%0d", tag, t), sc, longint'(k));
  endtask

  task automatic chk_zero(input string tag, input logic b, d, s, o,
                          input longint x, y, z, sc);
    chk({tag, " ctrl"}, longint'({b, d, s, o}), 0);
    chk({tag, " x"}, x, 0);
    chk({tag, " y"}, y, 0);
    chk({tag, " z"}, z, 0);
    chk({tag, " steps"}, sc, 0);
  endtask

  // Called at a falling edge; start is sampled at the next rising edge (cycle 0).
  task automatic run(input longint ix, iy, iz, sg, rh, bt,
                     input int n, input int stop_at, input int restart_at);
    int ne;
    ne = n;
    if (stop_at > 0 && ((stop_at - 1) / 5 + 1) < ne) ne = (stop_at - 1) / 5 + 1;
    nrun = ne;
    model(ix, iy, iz, sg, rh, bt, ne);
    initial_x = 27'(ix); initial_y = 27'(iy); initial_z = 27'(iz);
    sigma = 27'(sg); rho = 27'(rh); beta = 27'(bt);
    num_steps = 32'(n);
    start = 1'b1;
    for (int t = 1; t <= 5 * ne + 3; t++) begin
      @(negedge clk);
      start = (t == restart_at);
      stop  = (t == stop_at);
      chk_inst("sat", t, 1, 0, bz0, dn0, sv0, ov0, x0, y0, z0, sc0);
      chk_inst("dec", t, 4, 0, bz1, dn1, sv1, ov1, x1, y1, z1, sc1);
      chk_inst("wrap", t, 1, 1, bz2, dn2, sv2, ov2, x2, y2, z2, sc2);
    end
    start = 1'b0;
    stop  = 1'b0;
  endtask

  function automatic longint rnd(input int mag);
    return longint'($urandom_range(0, 2 * mag)) - longint'(mag);
  endfunction

  initial begin
    repeat (2) @(negedge clk);
    chk_zero("reset sat", bz0, dn0, sv0, ov0, x0, y0, z0, sc0);
    chk_zero("reset wrap", bz2, dn2, sv2, ov2, x2, y2, z2, sc2);
    reset = 1'b0;
    @(negedge clk);

    run(-1048576, 104858, 26214400, 10485760, 29360128, 2796203, 1, 0, 0);
    chk("single x", x0, -1003520);
    run(0, 0, 0, 10485760, 29360128, 2796203, 100, 0, 0);
    run(1048576, 2097152, 20971520, 10485760, 29360128, 2796203, 10, 0, 0);
    run(-1048576, 104858, 26214400, 10485760, 29360128, 2796203, 1000, 13, 0);
    run(2097152, -3145728, 10485760, 10485760, 29360128, 2796203, 3, 0, 0);
    run(66060288, 41943040, -66060288, 10485760, 66060288, 2796203, 1, 0, 0);
    chk("sat y", y0, 67108863);
    chk("wrap y", y2, -59924480);
    chk("wrap ovf", longint'(ov2), 1);
    run(rnd(30 << 20), rnd(30 << 20), rnd(30 << 20), 10485760, 29360128, 2796203, 6, 0, 7);
    run(rnd(30 << 20), rnd(30 << 20), rnd(30 << 20), 10485760, 29360128, 2796203, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      int mag;
      mag = (i % 3 == 2) ? (63 << 20) : (30 << 20);
      run(rnd(mag), rnd(mag), rnd(mag), longint'($urandom_range(0, 20 << 20)),
          longint'($urandom_range(0, 40 << 20)), longint'($urandom_range(0, 4 << 20)),
          int'($urandom_range(1, 12)), 0, 0);
    end

    // Reset in the middle of M1 of step 2: outputs clear at once, no done follows.
    initial_x = 27'(1048576); initial_y = 27'(2097152); initial_z = 27'(3145728);
    num_steps = 32'd20;
    start = 1'b1;
    for (int t = 1; t <= 7; t++) begin
      @(negedge clk);
      start = 1'b0;
    end
    reset = 1'b1;
    #1;
    chk_zero("midreset sat", bz0, dn0, sv0, ov0, x0, y0, z0, sc0);
    chk_zero("midreset dec", bz1, dn1, sv1, ov1, x1, y1, z1, sc1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 1) reset = 1'b0;
      chk_zero($sformatf("postreset %0d", i), bz0, dn0, sv0, ov0, x0, y0, z0, sc0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/lorenz_stepper.md
Name: lorenz_stepper

Overview:
- Parametrised, handshaked successor to the free-running three-integrator Lorenz solver.
- Advances the Lorenz state (x, y, z) by forward-Euler steps with dt = 2^-DT_SHIFT.
- Shares one signed multiplier across four time-multiplexed multiply phases.
- Supports a bounded run length, optional saturation and decimated sample output; feeds the VGA/plot and HPS readout paths.

Parameters:
- WIDTH, 27: state, coefficient and output word width, signed fixed point.
- FRAC, 20: fraction bits. The default gives 7.20 format.
- DT_SHIFT, 8: Euler step; dt = 2^-DT_SHIFT.
- DECIM, 1: sample_valid pulses once every DECIM completed steps.
- CNT_W, 32: width of num_steps and step_count.
- SATURATE, 1: 1 = clamp new state to the WIDTH range; 0 = two's-complement wrap.

Ports:
- clk, in, 1: system clock.
- reset, in, 1: asynchronous, active-high reset.
- start, in, 1: one-cycle request. Honoured only in IDLE.
- stop, in, 1: abort request. Honoured at the next step boundary.
- num_steps, in, CNT_W: number of Euler steps to run. Latched on start.
- initial_x, initial_y, initial_z, in, WIDTH each: initial state. Latched on start.
- sigma, rho, beta, in, WIDTH each: Lorenz coefficients. Latched on start.
- x_out, y_out, z_out, out, WIDTH each: current state registers.
- sample_valid, out, 1: one-cycle strobe; x/y/z_out are a decimated sample this cycle.
- busy, out, 1: high from the cycle after start until done.
- done, out, 1: one-cycle strobe marking the end of a run.
- step_count, out, CNT_W: steps completed in the current or last run.
- overflow, out, 1: sticky. Set when any new state value exceeds the WIDTH range. Cleared on start.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high (ports clk, reset).
- Reset, asserted at any time including mid-run:
  - FSM goes to IDLE immediately.
  - All outputs and internal registers are 0.
  - No done pulse is generated for the aborted run.
- FSM states: IDLE, M0, M1, M2, M3, UPD.
- IDLE with start=1:
  - Latch inputs; x/y/z_out <= initial_*.
  - Clear step_count, overflow and the decimation counter.
  - If num_steps==0: done=1 the next cycle and stay in IDLE (busy stays 0).
  - Otherwise busy=1 and go to M0.
- Multiply phases, one per cycle. A product is the full 2*WIDTH-bit result of a*b, arithmetic-shifted right by FRAC:
  - M0: p0 = sigma*(y-x).
  - M1: p1 = x*(rho-z).
  - M2: p2 = x*y.
  - M3: p3 = beta*z.
- Differences are formed at WIDTH+1 bits. No intermediate wrap is permitted.
- UPD: form derivatives at 2*WIDTH bits:
  - dx = p0.
  - dy = p1 - y.
  - dz = p2 - p3.
  - Each new value = old + (d >>> DT_SHIFT), computed at 2*WIDTH bits.
  - If the result is outside [-2^(WIDTH-1), 2^(WIDTH-1)-1]: overflow <= 1, and the value is clamped (SATURATE=1) or truncated to WIDTH bits (SATURATE=0).
  - x/y/z_out and step_count+1 update together at the end of UPD.
- Step period is 5 cycles. Start in cycle 0 means the first updated state is visible in cycle 6.
- Decimation: the counter increments per step. On reaching DECIM it resets to 0 and sample_valid=1 in the cycle after UPD, when the new state is on the outputs.
- End of run, after UPD: if step_count+1 == num_steps or stop was seen since the last boundary:
  - done=1 in the next cycle (the same cycle as any sample_valid).
  - busy=0 and return to IDLE.
  - Otherwise go to M0.
- stop is captured into a pending flag in any busy state. The current step always completes; there is no partial update.
- start while busy is ignored.
- reset has priority over start/stop in the same cycle.
- Outputs hold their last values in IDLE until the next start.

Test Plan:
- Single Euler step: sigma=10485760, rho=29360128, beta=2796203, initial (-1048576, 104858, 26214400), num_steps=1, DECIM=1, start at cycle 0 -> busy 1..5; x_out=-1003520, with sample_valid and done in cycle 6; step_count=1; overflow=0.
- Equilibrium: all initial values 0, sigma/rho/beta as above, num_steps=100 -> x/y/z_out remain 0 throughout; 100 sample_valid pulses 5 cycles apart; done once; step_count=100.
- Decimation: DECIM=4, num_steps=10 -> exactly 2 sample_valid pulses (after steps 4 and 8); done after step 10 with no sample_valid; step_count=10.
- Stop: num_steps=1000, stop pulsed during M2 of step 3 -> step 3 completes; done after step 3; step_count=3; a further start is accepted in IDLE.
- Saturation: initial (66060288, 41943040, -66060288), rho=66060288, num_steps=1:
  - SATURATE=1 -> y_out=67108863, overflow=1.
  - SATURATE=0 -> y_out equals the WIDTH-bit wrap of the 70.85 result (a negative value); overflow=1.
- Reset and ignored start: reset asserted mid-M1 -> all outputs 0 immediately, no done pulse. Separately, start re-pulsed while busy -> ignored; run length unchanged.
